// File: rtl/alu_issue_stage.sv
// Operand-issue stage in front of the ALU logic unit: decodes opcodes into
// logic-unit selects and buffers requests in a 2-entry in-order queue.
module alu_issue_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_alu_op0,
  output logic             out_alu_op1,
  output logic [TAGW-1:0]  out_tag,
  output logic             err_pulse,
  output logic [7:0]       err_count
);

  localparam int unsigned ERRW = 8;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAGW-1:0]  tag;
    logic             op0;
    logic             op1;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  entry_t          head_q, head_d;
  entry_t          tail_q, tail_d;
  logic            err_pulse_q, err_pulse_d;
  logic [ERRW-1:0] err_count_q, err_count_d;

  entry_t in_entry;
  logic   accept;
  logic   push;
  logic   illegal;
  logic   pop;

  // Opcode bit 1 picks the OR/NOR group, bit 0 picks the XOR/NOR flavour.
  always_comb begin
    in_entry.a   = in_a;
    in_entry.b   = in_b;
    in_entry.tag = in_tag;
    in_entry.op0 = in_op[1];
    in_entry.op1 = in_op[0];
  end

  assign in_ready  = (state_q != ST_FULL) && !rst;
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign push      = accept && !in_op[2];
  assign illegal   = accept && in_op[2];
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    err_pulse_d = illegal;
    err_count_d = err_count_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          head_d  = in_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_d = in_entry;
        end else if (push) begin
          tail_d  = in_entry;
          state_d = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a pop can happen
        if (pop) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (flush) begin
      state_d = ST_EMPTY;
    end

    if (illegal && (err_count_q != {ERRW{1'b1}})) begin
      err_count_d = err_count_q + ERRW'(1);
    end
  end

  assign out_a       = head_q.a;
  assign out_b       = head_q.b;
  assign out_tag     = head_q.tag;
  assign out_alu_op0 = head_q.op0;
  assign out_alu_op1 = head_q.op1;
  assign err_pulse   = err_pulse_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a, out_b;
  logic        out_alu_op0, out_alu_op1;
  logic [3:0]  out_tag;
  logic        err_pulse;
  logic [7:0]  err_count;

  alu_issue_stage #(.WIDTH(32), .TAGW(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b),
    .out_alu_op0(out_alu_op0), .out_alu_op1(out_alu_op1),
    .out_tag(out_tag), .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic        op0;
    logic        op1;
  } ent_t;

  ent_t q[$];
  int   exp_cnt;
  bit   exp_pulse;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_cnt   = 0;
    exp_pulse = 0;
  endtask

  // Compare DUT outputs with the model, then drive one cycle of stimulus
  // and advance the model by the effect of the coming clock edge.
  task automatic step(input bit v, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] tag,
                      input bit ordy, input bit fl);
    bit   rdy, acc, pop;
    ent_t e;
    @(negedge clk);
    check("out_valid", out_valid, q.size() > 0);
    check("in_ready", in_ready, q.size() < 2);
    check("err_pulse", err_pulse, exp_pulse);
    check("err_count", err_count, exp_cnt);
    if (q.size() > 0) begin
      check("out_a", out_a, q[0].a);
      check("out_b", out_b, q[0].b);
      check("out_tag", out_tag, q[0].tag);
      check("alu_op", {out_alu_op0, out_alu_op1}, {q[0].op0, q[0].op1});
    end
    in_valid = v; in_op = op; in_a = a; in_b = b; in_tag = tag;
    out_ready = ordy; flush = fl;
    rdy = q.size() < 2;
    acc = v && rdy;
    pop = (q.size() > 0) && ordy;
    exp_pulse = acc && (op >= 3'd4);
    if (exp_pulse && exp_cnt < 255) exp_cnt++;
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc && op < 3'd4) begin
        e.a = a; e.b = b; e.tag = tag;
        e.op0 = (op == 3'd2) || (op == 3'd3);
        e.op1 = (op == 3'd1) || (op == 3'd3);
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 3'd0, 32'd0, 32'd0, 4'd0, ordy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 3'd0;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", {out_a, out_b}, 64'd0);
    check("rst_misc", {out_tag, out_alu_op0, out_alu_op1, err_pulse, err_count}, 16'd0);
    rst = 1'b0;

    // single AND request with downstream ready
    step(1'b1, 3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd3, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // XOR, OR, NOR with downstream stalled; third is held off by in_ready
    step(1'b1, 3'b001, 32'h1111_1111, 32'h2222_2222, 4'd1, 1'b0, 1'b0);
    step(1'b1, 3'b010, 32'h3333_3333, 32'h4444_4444, 4'd2, 1'b0, 1'b0);
    step(1'b1, 3'b011, 32'h5555_5555, 32'h6666_6666, 4'd3, 1'b0, 1'b0);
    step(1'b1, 3'b011, 32'h5555_5555, 32'h6666_6666, 4'd3, 1'b1, 1'b0);
    step(1'b1, 3'b011, 32'h5555_5555, 32'h6666_6666, 4'd3, 1'b1, 1'b0);
    repeat (3) idle(1'b1);

    // illegal opcodes: single, then saturation
    step(1'b1, 3'b101, 32'hDEAD_BEEF, 32'h0, 4'd7, 1'b1, 1'b0);
    repeat (2) idle(1'b1);
    for (int i = 0; i < 300; i++)
      step(1'b1, 3'(4 + (i % 4)), $urandom, $urandom, 4'(i), 1'b1, 1'b0);
    repeat (2) idle(1'b1);

    // count=1 with continuous push and pop: no bubble, never full
    step(1'b1, 3'b000, 32'hA, 32'hB, 4'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++)
      step(1'b1, 3'(i % 4), $urandom, $urandom, 4'(i), 1'b1, 1'b0);
    repeat (2) idle(1'b1);

    // flush while full, with a legal push offered in the same cycle
    step(1'b1, 3'b001, 32'h1, 32'h2, 4'd4, 1'b0, 1'b0);
    step(1'b1, 3'b010, 32'h3, 32'h4, 4'd5, 1'b0, 1'b0);
    step(1'b1, 3'b000, 32'h7, 32'h8, 4'd6, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // asynchronous reset while full
    step(1'b1, 3'b001, 32'h11, 32'h22, 4'd8, 1'b0, 1'b0);
    step(1'b1, 3'b011, 32'h33, 32'h44, 4'd9, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_err_count", err_count, 8'd0);
    check("async_in_ready", in_ready, 1'b0);
    check("async_out_tag", out_tag, 4'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 3'b010, 32'hCAFE_0001, 32'hCAFE_0002, 4'd12, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // random traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom % 4) != 0, ($urandom % 5 == 0) ? 3'(4 + $urandom % 4) : 3'($urandom % 4),
           $urandom, $urandom, 4'($urandom), ($urandom % 3) != 0, ($urandom % 32) == 0);
    repeat (3) idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
